// File: rtl/amp_i2c_cfg_seq.sv
// Amplifier configuration sequencer: after a power-up delay, walks a register table and
// issues one I2C register write per entry, retrying NACKed or timed-out writes.
module amp_i2c_cfg_seq #(
  parameter int unsigned NUM_REGS       = 8,
  parameter logic [6:0]  DEV_ADDR       = 7'h2C,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned WAIT_CYCLES    = 1000,
  parameter int unsigned GAP_CYCLES     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          send_cfg,
  output logic [IW-1:0] tbl_addr,
  input  logic [15:0]   tbl_data,
  output logic          wr_req,
  input  logic          wr_ready,
  output logic [6:0]    wr_dev,
  output logic [7:0]    wr_reg,
  output logic [7:0]    wr_data,
  input  logic          wr_done,
  input  logic          wr_nack,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [IW-1:0] err_index
);

  localparam int unsigned MAXC0 = (WAIT_CYCLES > GAP_CYCLES) ? WAIT_CYCLES : GAP_CYCLES;
  localparam int unsigned MAXC  = (MAXC0 > TIMEOUT_CYCLES) ? MAXC0 : TIMEOUT_CYCLES;
  localparam int unsigned CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_REQ, S_WAIT, S_GAP, S_DONE, S_ERROR
  } state_e;

  state_e        state_q;
  logic          send_prev_q;
  logic [IW-1:0] idx_q;
  logic [RW-1:0] retry_q;
  logic [CW-1:0] cnt_q;
  logic          gap_to_fetch_q;
  logic          wr_req_q;
  logic [7:0]    wr_reg_q;
  logic [7:0]    wr_data_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic [IW-1:0] err_index_q;
  logic          trig;

  // PWRUP, WAIT and GAP never overlap, so they share one counter; a limit of 0 still costs one cycle.
  function automatic logic expired(input logic [CW-1:0] c, input int unsigned lim);
    return (32'(c) + 32'd1) >= lim;
  endfunction

  assign trig = send_cfg & ~send_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      send_prev_q    <= 1'b0;
      idx_q          <= '0;
      retry_q        <= '0;
      cnt_q          <= '0;
      gap_to_fetch_q <= 1'b0;
      wr_req_q       <= 1'b0;
      wr_reg_q       <= '0;
      wr_data_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_index_q    <= '0;
    end else begin
      send_prev_q <= send_cfg;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (trig) begin
            state_q     <= S_PWRUP;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            cnt_q       <= '0;
          end
        end
        S_PWRUP: begin
          if (expired(cnt_q, WAIT_CYCLES)) begin
            cnt_q   <= '0;
            state_q <= S_FETCH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FETCH: begin
          if (tbl_data[15:8] == 8'hFF) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            wr_reg_q  <= tbl_data[15:8];
            wr_data_q <= tbl_data[7:0];
            wr_req_q  <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (wr_ready) begin
            wr_req_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A completion in the expiry cycle wins because wr_done is examined first.
          if (wr_done || expired(cnt_q, TIMEOUT_CYCLES)) begin
            cnt_q <= '0;
            if (wr_done && !wr_nack) begin
              if (32'(idx_q) == NUM_REGS - 1) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q          <= idx_q + IW'(1);
                retry_q        <= '0;
                gap_to_fetch_q <= 1'b1;
                state_q        <= S_GAP;
              end
            end else if (32'(retry_q) >= MAX_RETRY) begin
              state_q     <= S_ERROR;
              busy_q      <= 1'b0;
              error_q     <= 1'b1;
              err_index_q <= idx_q;
            end else begin
              retry_q        <= retry_q + RW'(1);
              gap_to_fetch_q <= 1'b0;
              state_q        <= S_GAP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_GAP: begin
          if (expired(cnt_q, GAP_CYCLES)) begin
            cnt_q <= '0;
            if (gap_to_fetch_q) begin
              state_q <= S_FETCH;
            end else begin
              wr_req_q <= 1'b1;
              state_q  <= S_REQ;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The engine shares this reset, so the request is withdrawn in the reset cycle itself.
  assign wr_req    = wr_req_q & ~reset;
  assign tbl_addr  = idx_q;
  assign wr_dev    = DEV_ADDR;
  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;

endmodule
